stage_if_fetchq: RTL and testbench

Parametrised instruction-fetch stage with a decoupled, variable-latency instruction-memory interface and an in-order fetch queue of depth FQ_DEPTH. It owns the fetch PC and issues sequential fetch requests. It buffers returned instructions with their PCs and presents the queue head to ID. Branch/jump redirects flush the queue and discard in-flight responses. Sits between the PC/imem and the IF/ID boundary; it replaces the single-cycle combinational fetch path.

---
 rtl/stage_if_fetchq_pkg.sv | 14 +
 rtl/stage_if_fetchq_if.sv | 28 ++
 rtl/stage_if_fetchq_fetch_queue.sv | 55 +++++
 rtl/stage_if_fetchq.sv | 95 +++++++++
 tb/tb_stage_if_fetchq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/stage_if_fetchq_pkg.sv
// Shared constants for the decoupled instruction-fetch stage.
package stage_if_fetchq_pkg;

   localparam int unsigned MEM_ADDR_W   = 32;
   localparam int unsigned MEM_WORD_W   = 32;
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Width of a counter that must hold values 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stage_if_fetchq_if.sv
// Fetch-stage bus: control from EX, imem request/response, and the IF/ID head.
interface stage_if_fetchq_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32
);

   logic                  redirect_en;
   logic [ADDR_WIDTH-1:0] redirect_tgt;
   logic                  stall_en;
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_rvalid;
   logic [WORD_WIDTH-1:0] imem_rdata;
   logic [WORD_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  inst_valid;

   modport master (
      input  redirect_en, redirect_tgt, stall_en, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, inst, inst_pc, inst_valid
   );

   modport slave (
      output redirect_en, redirect_tgt, stall_en, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, inst, inst_pc, inst_valid
   );

endinterface

// File: rtl/stage_if_fetchq_fetch_queue.sv
// Synchronous FIFO with flush; holds {instruction, pc} pairs for the fetch stage.
module stage_if_fetchq_fetch_queue
   import stage_if_fetchq_pkg::*;
#(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = cnt_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic             o_empty,
   output logic             o_full
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;

   assign w_wr = i_rst_n & i_push & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/stage_if_fetchq.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential imem requests and
// queues in-order responses for ID; redirects flush the queue and drop stale responses.
module stage_if_fetchq
   import stage_if_fetchq_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned           WORD_WIDTH = MEM_WORD_W,
   parameter int unsigned           FQ_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
   parameter logic [WORD_WIDTH-1:0] NOP_INST   = WORD_WIDTH'(DEF_NOP_INST)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   stage_if_fetchq_if.master  bus
);

   localparam int unsigned CW = cnt_width(FQ_DEPTH);
   localparam int unsigned EW = WORD_WIDTH + ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_rsp_pc;
   logic [CW-1:0]         r_outstanding;
   logic [CW-1:0]         r_drop;

   logic [ADDR_WIDTH-1:0] w_tgt;
   logic [CW:0]           w_inflight;
   logic                  w_req;
   logic                  w_rsp;
   logic                  w_rsp_drop;
   logic                  w_push;
   logic                  w_pop;
   logic [EW-1:0]         w_fq_rdata;
   logic [CW-1:0]         w_fq_count;
   logic                  w_fq_empty;
   logic                  w_fq_full;
   logic                  w_unused_tgt_lsb;

   assign w_tgt            = {bus.redirect_tgt[ADDR_WIDTH-1:2], 2'b00};
   assign w_unused_tgt_lsb = ^bus.redirect_tgt[1:0];

   // Queued plus in-flight entries never exceed the queue depth, so a push always fits.
   assign w_inflight = {1'b0, w_fq_count} + {1'b0, r_outstanding};
   assign w_req      = i_rst_n & ~bus.redirect_en & ~w_fq_full
                     & (w_inflight < (CW+1)'(FQ_DEPTH));

   // A response with nothing outstanding is a stray from before a reset.
   assign w_rsp      = bus.imem_rvalid & (r_outstanding != '0);
   assign w_rsp_drop = w_rsp & (r_drop != '0);
   assign w_push     = w_rsp & (r_drop == '0) & ~bus.redirect_en;
   assign w_pop      = ~w_fq_empty & ~bus.stall_en & ~bus.redirect_en;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_req) - CW'(w_rsp);
         if (bus.redirect_en) begin
            r_fetch_pc <= w_tgt;
            r_rsp_pc   <= w_tgt;
            // Everything still in flight after this edge is stale.
            r_drop     <= r_outstanding - CW'(w_rsp);
         end else begin
            if (w_req)      r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            if (w_push)     r_rsp_pc   <= r_rsp_pc + ADDR_WIDTH'(4);
            if (w_rsp_drop) r_drop     <= r_drop - 1'b1;
         end
      end
   end

   stage_if_fetchq_fetch_queue #(
      .WIDTH (EW),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_en),
      .i_wdata ({bus.imem_rdata, r_rsp_pc}),
      .o_rdata (w_fq_rdata),
      .o_count (w_fq_count),
      .o_empty (w_fq_empty),
      .o_full  (w_fq_full)
   );

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_fetch_pc;
   assign bus.inst_valid = ~w_fq_empty;
   assign bus.inst       = w_fq_empty ? NOP_INST : w_fq_rdata[EW-1 -: WORD_WIDTH];
   assign bus.inst_pc    = w_fq_empty ? '0 : w_fq_rdata[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_stage_if_fetchq.sv
// Bench for stage_if_fetchq: variable-latency imem model plus a queue-level reference model.
module tb_stage_if_fetchq;

   localparam int unsigned AW    = 32;
   localparam int unsigned WW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stage_if_fetchq_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

   stage_if_fetchq #(
      .ADDR_WIDTH (AW),
      .WORD_WIDTH (WW),
      .FQ_DEPTH   (DEPTH),
      .RESET_PC   (32'h0),
      .NOP_INST   (NOP)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
   typedef struct {logic [31:0] addr; bit live;} fl_t;
   typedef struct {logic [31:0] addr; int due;} pend_t;

   ent_t  eq[$];    // instructions ID should see, head first
   fl_t   infl[$];  // requests the fetch stage has issued and not yet had answered
   pend_t pend[$];  // imem-side pending responses
   logic [31:0] m_pc;
   int cyc      = 0;
   int checks   = 0;
   int errors   = 0;
   int lat_min  = 1;
   int lat_max  = 1;
   int last_due = 0;
   bit chk_en   = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs, advance imem and reference model.
   task automatic cycle(input bit rst, input bit redir, input logic [31:0] tgt,
                        input bit stall, input bit stray);
      bit          rv;
      bit          exp_req;
      bit          do_pop;
      logic [31:0] rd;
      fl_t         f;
      rst_n            = rst;
      bus.redirect_en  = redir;
      bus.redirect_tgt = tgt;
      bus.stall_en     = stall;
      rv = 1'b0;
      rd = $urandom;
      if (stray) begin
         rv = 1'b1;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
         rv = 1'b1;
         rd = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      #1;
      exp_req = rst && !redir && (eq.size() + infl.size() < DEPTH);
      if (chk_en) begin
         check("imem_req", 32'(bus.imem_req), 32'(exp_req));
         if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
         check("inst_valid", 32'(bus.inst_valid), 32'(eq.size() > 0));
         check("inst", bus.inst, (eq.size() > 0) ? eq[0].data : NOP);
         check("inst_pc", bus.inst_pc, (eq.size() > 0) ? eq[0].pc : 32'h0);
      end
      if (bus.imem_req === 1'b1) begin
         int d;
         d = cyc + int'($urandom_range(lat_max, lat_min));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         pend.push_back('{bus.imem_addr, d});
      end
      do_pop = (eq.size() > 0) && !stall && !redir;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         eq.delete();
         infl.delete();
         pend.delete();
         last_due = cyc;
         m_pc     = 32'h0;
      end else begin
         if (do_pop) void'(eq.pop_front());
         if (rv && infl.size() > 0) begin
            f = infl.pop_front();
            if (f.live && !redir) eq.push_back('{f.addr, mem_word(f.addr)});
         end
         if (redir) begin
            eq.delete();
            foreach (infl[i]) infl[i].live = 1'b0;
            m_pc = {tgt[31:2], 2'b00};
         end else if (exp_req) begin
            infl.push_back('{m_pc, 1'b1});
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   initial begin
      m_pc = 32'h0;
      // Registers are unknown until the first reset edge.
      repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_en = 1'b1;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Latency 1, free-running
      repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Long stall, then release
      repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Latency 3, redirect with requests in flight
      lat_min = 3;
      lat_max = 3;
      repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && infl.size() < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      repeat (15) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Unaligned redirect target
      cycle(1'b1, 1'b1, 32'h103, 1'b0, 1'b0);
      repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Redirect coinciding with a response and a stall
      lat_min = 1;
      lat_max = 1;
      repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && !(pend.size() > 0 && pend[0].due <= cyc); i++)
         cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
      repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // PC wrap-around
      cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
      repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Randomized traffic: variable latency, stalls, redirects
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         cycle(1'b1, ($urandom_range(99, 0) < 4), $urandom, ($urandom_range(3, 0) == 0), 1'b0);
      end

      // Reset mid-stream with responses outstanding, then a stray response
      lat_min = 3;
      lat_max = 3;
      repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
